// File: rtl/control.sv
// Single-cycle accumulator core: every rising edge executes the opcode on instr
// against accumulator A and operand B, with carry/zero flags and a registered output port.
module control #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] portin,
  input  logic [3:0]       instr,
  output logic [WIDTH-1:0] portout
);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_INC  = 4'b0001;
  localparam logic [3:0] OP_DEC  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_MOVB = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_IN   = 4'b0110;
  localparam logic [3:0] OP_OUT  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_CLR  = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1010;
  localparam logic [3:0] OP_OR   = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_SHR  = 4'b1110;
  localparam logic [3:0] OP_SWAP = 4'b1111;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic [WIDTH-1:0] portout_q, portout_d;
  logic             a_wr;

  // One extra bit catches carry out of ADD/INC and borrow out of SUB/DEC.
  logic [WIDTH:0] add_res, sub_res, inc_res, dec_res;

  always_comb begin
    add_res = {1'b0, a_q} + {1'b0, b_q};
    sub_res = {1'b0, a_q} - {1'b0, b_q};
    inc_res = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
    dec_res = {1'b0, a_q} - {{WIDTH{1'b0}}, 1'b1};
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    portout_d = portout_q;
    a_wr      = 1'b1;
    case (instr)
      OP_INC:  begin a_d = inc_res[WIDTH-1:0]; c_d = inc_res[WIDTH]; end
      OP_DEC:  begin a_d = dec_res[WIDTH-1:0]; c_d = dec_res[WIDTH]; end
      OP_NOT:  a_d = ~a_q;
      OP_MOVB: begin b_d = a_q; a_wr = 1'b0; end
      OP_ADD:  begin a_d = add_res[WIDTH-1:0]; c_d = add_res[WIDTH]; end
      OP_IN:   a_d = portin;
      OP_OUT:  begin portout_d = a_q; a_wr = 1'b0; end
      OP_SUB:  begin a_d = sub_res[WIDTH-1:0]; c_d = sub_res[WIDTH]; end
      OP_CLR:  begin a_d = '0; b_d = '0; c_d = 1'b0; end
      OP_AND:  a_d = a_q & b_q;
      OP_OR:   a_d = a_q | b_q;
      OP_XOR:  a_d = a_q ^ b_q;
      OP_SHL:  begin a_d = {a_q[WIDTH-2:0], 1'b0}; c_d = a_q[WIDTH-1]; end
      OP_SHR:  begin a_d = {1'b0, a_q[WIDTH-1:1]}; c_d = a_q[0]; end
      OP_SWAP: begin a_d = b_q; b_d = a_q; end
      OP_NOP:  a_wr = 1'b0;
      default: a_wr = 1'b0;
    endcase
    // Zero flag tracks only instructions that actually write the accumulator.
    z_d = a_wr ? (a_d == '0) : z_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      portout_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      z_q       <= z_d;
      portout_q <= portout_d;
    end
  end

  assign portout = portout_q;

endmodule

// File: tb/tb_control.sv
// Randomised bench for the accumulator core: a behavioural model tracks every
// edge and one compare process checks the core each cycle, plus literal spot checks.
module tb_control;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] portin = '0;
  logic [3:0]   instr = '0;
  logic [W-1:0] portout;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  control #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .portin  (portin),
    .instr   (instr),
    .portout (portout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         z;
    logic [W-1:0] p;
  } st_t;

  st_t m;

  // Next state from the opcode table, using integer arithmetic and comparisons.
  function automatic st_t apply(st_t s, logic [3:0] op, logic [W-1:0] pin);
    st_t n = s;
    int  a = int'(s.a);
    int  b = int'(s.b);
    int  r = a;
    bit  wr = 1'b1;
    case (op)
      4'd1:  begin r = (a + 1) & MASK; n.c = (a == MASK); end
      4'd2:  begin r = (a - 1) & MASK; n.c = (a == 0); end
      4'd3:  r = MASK - a;
      4'd4:  begin n.b = s.a; wr = 1'b0; end
      4'd5:  begin r = (a + b) & MASK; n.c = (a + b > MASK); end
      4'd6:  r = int'(pin);
      4'd7:  begin n.p = s.a; wr = 1'b0; end
      4'd8:  begin r = (a - b) & MASK; n.c = (a < b); end
      4'd9:  begin r = 0; n.b = '0; n.c = 1'b0; end
      4'd10: r = a & b;
      4'd11: r = a | b;
      4'd12: r = a ^ b;
      4'd13: begin r = (a * 2) & MASK; n.c = (a >= (1 << (W - 1))); end
      4'd14: begin r = a / 2; n.c = (a % 2 == 1); end
      4'd15: begin r = b; n.b = s.a; end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      n.a = r[W-1:0];
      n.z = (r == 0);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= apply(m, instr, portin);
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, settled well after the active edge.
  always @(posedge clk) begin
    #3;
    if (cmp_en) begin
      cmp("model_portout", int'(portout), int'(m.p));
      cmp("model_a", int'(dut.a_q), int'(m.a));
      cmp("model_b", int'(dut.b_q), int'(m.b));
      cmp("model_c", int'(dut.c_q), int'(m.c));
      cmp("model_z", int'(dut.z_q), int'(m.z));
    end
  end

  task automatic step(input logic [3:0] op, input logic [W-1:0] pin);
    @(negedge clk);
    instr  = op;
    portin = pin;
    @(posedge clk);
    #4;
    $display("op=%b portin=%b -> portout=%b", op, pin, portout);
  endtask

  initial begin
    // Reset state, checked while reset is held.
    repeat (2) @(negedge clk);
    cmp("reset_portout", int'(portout), 0);
    cmp("reset_a", int'(dut.a_q), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    step(4'd9, 4'd0);
    step(4'd6, 4'b0011);  cmp("in_a", int'(dut.a_q), 3);
    step(4'd4, 4'd0);     cmp("movb_b", int'(dut.b_q), 3);
    step(4'd5, 4'd0);     cmp("add_a", int'(dut.a_q), 6); cmp("add_c", int'(dut.c_q), 0);
    step(4'd7, 4'd0);     cmp("out_portout", int'(portout), 6);
    step(4'd0, 4'd9);
    step(4'd0, 4'd2);     cmp("hold_portout", int'(portout), 6);

    step(4'd6, 4'b1111);
    step(4'd1, 4'd0);     cmp("inc_wrap_a", int'(dut.a_q), 0); cmp("inc_c", int'(dut.c_q), 1);
                          cmp("inc_z", int'(dut.z_q), 1);
    step(4'd2, 4'd0);     cmp("dec_wrap_a", int'(dut.a_q), 15); cmp("dec_c", int'(dut.c_q), 1);
                          cmp("dec_z", int'(dut.z_q), 0);

    step(4'd6, 4'b0101);
    step(4'd4, 4'd0);
    step(4'd6, 4'b0011);
    step(4'd8, 4'd0);     cmp("sub_a", int'(dut.a_q), 14); cmp("sub_c", int'(dut.c_q), 1);
    step(4'd10, 4'd0);    cmp("and_a", int'(dut.a_q), 4);
    step(4'd11, 4'd0);    cmp("or_a", int'(dut.a_q), 5);
    step(4'd12, 4'd0);    cmp("xor_a", int'(dut.a_q), 0); cmp("xor_z", int'(dut.z_q), 1);

    step(4'd6, 4'b1001);
    step(4'd13, 4'd0);    cmp("shl_a", int'(dut.a_q), 2); cmp("shl_c", int'(dut.c_q), 1);
    step(4'd14, 4'd0);    cmp("shr_a", int'(dut.a_q), 1); cmp("shr_c", int'(dut.c_q), 0);
    step(4'd3, 4'd0);     cmp("not_a", int'(dut.a_q), 14);
    step(4'd15, 4'd0);    cmp("swap_a", int'(dut.a_q), 5); cmp("swap_b", int'(dut.b_q), 14);

    step(4'd6, 4'b0111);
    step(4'd7, 4'd0);     cmp("out7_portout", int'(portout), 7);
    // Asynchronous reset between edges must clear state without a clock.
    @(negedge clk);
    instr = 4'd0;
    #1 rst_n = 1'b0;
    #1;
    cmp("async_portout", int'(portout), 0);
    cmp("async_a", int'(dut.a_q), 0);
    cmp("async_b", int'(dut.b_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'd7, 4'd0);     cmp("post_reset_out", int'(portout), 0);

    step(4'd6, 4'b1010);
    step(4'd7, 4'd0);
    for (int i = 0; i < 5; i++) step(4'd0, 4'(i * 5 + 3));
    cmp("nop_toggle_portout", int'(portout), 10);
    cmp("nop_toggle_a", int'(dut.a_q), 10);

    // Random phase, biased toward OUT so accumulator values reach the port.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) op = 4'd7;
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(op, 4'($urandom));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
